// File: rtl/sp_run_ctrl.sv
// ---------------------------------------------------------------------------
// sp_run_ctrl
//
// Run controller for the SP core. A load-and-run sequence streams an image
// into the SP SRAM over a valid/ready handshake, holds the core in reset for
// HOLD_CYCLES cycles, releases it with core_start asserted and waits for
// core_halt. RUN cycles are counted (saturating) in cycle_count.
//
// Optional feature: define SP_RUN_WDOG_EN to enable a watchdog that ends the
// run with timeout=1 once MAX_CYCLES RUN cycles have elapsed without a halt.
// Without the macro, timeout stays 0 and RUN lasts until halt or reset.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   go           start a load-and-run sequence (accepted in IDLE/DONE)
//   img_valid    image word valid
//   img_data     image word
//   img_last     final image word
//   img_ready    controller accepts an image word (LOAD state)
//   mem_wr_en    SRAM write strobe (same cycle as the handshake)
//   mem_wr_addr  SRAM write address (load address counter)
//   mem_wr_data  SRAM write data (img_data passthrough)
//   core_reset   active-high reset to the SP core
//   core_start   SP start level (RUN state)
//   core_halt    SP halted (only observed in RUN)
//   busy         sequence in progress (LOAD/HOLD/RUN)
//   done         sequence finished (sticky until next go)
//   timeout      watchdog expired (sticky until next go)
//   load_err     image overflowed the SRAM (sticky until next go)
//   cycle_count  number of RUN cycles elapsed
// ---------------------------------------------------------------------------
module sp_run_ctrl #(
    parameter int          ADDR_W      = 10,
    parameter int          DATA_W      = 32,
    parameter int          HOLD_CYCLES = 10,
    parameter int          CNT_W       = 32,
    parameter int unsigned MAX_CYCLES  = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              img_valid,
    input  logic [DATA_W-1:0] img_data,
    input  logic              img_last,
    output logic              img_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              core_reset,
    output logic              core_start,
    input  logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("sp_run_ctrl: HOLD_CYCLES must be at least 1");
    end
    if (CNT_W < 32 && MAX_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_max
        $error("sp_run_ctrl: MAX_CYCLES must fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              handshake;
    logic              addr_at_end;
    logic              hold_end;
    logic              wdog_expire;

    assign handshake   = img_valid & img_ready;
    assign addr_at_end = (addr == {ADDR_W{1'b1}});
    assign hold_end    = (hold_cnt == HOLD_LAST);

    assign mem_wr_en   = handshake;
    assign mem_wr_addr = addr;
    assign mem_wr_data = img_data;

    // Expiry is flagged in the RUN cycle that brings the count to MAX_CYCLES,
    // so the final cycle_count equals MAX_CYCLES exactly, as with a halt.
`ifdef SP_RUN_WDOG_EN
    assign wdog_expire = (state == RUN) && (cycle_count == CNT_W'(MAX_CYCLES - 1));
`else
    assign wdog_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs. A halt takes priority over the
    // watchdog because it is checked first.
    always_comb begin
        next_state = state;
        img_ready  = 1'b0;
        core_reset = 1'b1;
        core_start = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                img_ready = 1'b1;
                busy      = 1'b1;
                if (img_valid) begin
                    if (img_last) begin
                        next_state = HOLD;
                    end else if (addr_at_end) begin
                        next_state = DONE;
                    end
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (hold_end) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                core_reset = 1'b0;
                core_start = 1'b1;
                if (core_halt || wdog_expire) begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: load address, hold timer, RUN cycle counter and sticky flags.
    // The address counter stops at the last SRAM word instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr        <= '0;
            hold_cnt    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        addr        <= '0;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        load_err    <= 1'b0;
                    end
                end
                LOAD: begin
                    hold_cnt <= '0;
                    if (handshake) begin
                        if (!addr_at_end) begin
                            addr <= addr + 1'b1;
                        end
                        if (!img_last && addr_at_end) begin
                            load_err <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                RUN: begin
                    if (cycle_count != {CNT_W{1'b1}}) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (core_halt) begin
                        done <= 1'b1;
                    end else if (wdog_expire) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sp_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_run_ctrl
//
// Directed bench for sp_run_ctrl with ADDR_W=2 (4-word SRAM), HOLD_CYCLES=10
// and MAX_CYCLES=50. Per-cycle vectors hold the inputs driven in a cycle and
// the outputs expected in that same cycle. Watchdog checks follow the
// SP_RUN_WDOG_EN macro so the bench matches the RTL build.
// ---------------------------------------------------------------------------
module tb_sp_run_ctrl;

    localparam int          ADDR_W      = 2;
    localparam int          DATA_W      = 32;
    localparam int          HOLD_CYCLES = 10;
    localparam int          CNT_W       = 32;
    localparam int unsigned MAX_CYCLES  = 50;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              go        = 1'b0;
    logic              img_valid = 1'b0;
    logic [DATA_W-1:0] img_data  = '0;
    logic              img_last  = 1'b0;
    logic              core_halt = 1'b0;
    logic              img_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              core_reset;
    logic              core_start;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              load_err;
    logic [CNT_W-1:0]  cycle_count;

    sp_run_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W),
        .MAX_CYCLES  (MAX_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .img_valid   (img_valid),
        .img_data    (img_data),
        .img_last    (img_last),
        .img_ready   (img_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .core_reset  (core_reset),
        .core_start  (core_start),
        .core_halt   (core_halt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .load_err    (load_err),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        go;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        halt;
        logic        rdy;
        logic        wr;
        logic [1:0]  addr;
        logic        rst;
        logic        st;
        logic        busy;
        logic        dn;
        logic        err;
        logic [31:0] cnt;
        logic        tmo;
    } vec_t;

    vec_t t_load[$];
    vec_t t_bp[$];
    vec_t t_ovf[$];
    int   total = 0;
    int   bad   = 0;

    // Builds one vector: inputs (go, valid, data, last, halt) followed by
    // expected outputs (ready, wr_en, addr, core_reset, core_start, busy,
    // done, load_err, cycle_count, timeout).
    function automatic vec_t mk(input int go_i, valid_i, data_i, last_i, halt_i,
                                rdy_i, wr_i, addr_i, rst_i, st_i, busy_i,
                                dn_i, err_i, cnt_i, tmo_i);
        vec_t v;
        v.go    = go_i[0];
        v.valid = valid_i[0];
        v.data  = 32'(data_i);
        v.last  = last_i[0];
        v.halt  = halt_i[0];
        v.rdy   = rdy_i[0];
        v.wr    = wr_i[0];
        v.addr  = addr_i[1:0];
        v.rst   = rst_i[0];
        v.st    = st_i[0];
        v.busy  = busy_i[0];
        v.dn    = dn_i[0];
        v.err   = err_i[0];
        v.cnt   = 32'(cnt_i);
        v.tmo   = tmo_i[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a vector's inputs just after the rising edge, then let the
    // combinational outputs settle before they are sampled.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        go        = v.go;
        img_valid = v.valid;
        img_data  = v.data;
        img_last  = v.last;
        core_halt = v.halt;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        check({tag, " img_ready"},   32'(img_ready),   32'(v.rdy));
        check({tag, " mem_wr_en"},   32'(mem_wr_en),   32'(v.wr));
        check({tag, " mem_wr_addr"}, 32'(mem_wr_addr), 32'(v.addr));
        check({tag, " mem_wr_data"}, mem_wr_data,      v.data);
        check({tag, " core_reset"},  32'(core_reset),  32'(v.rst));
        check({tag, " core_start"},  32'(core_start),  32'(v.st));
        check({tag, " busy"},        32'(busy),        32'(v.busy));
        check({tag, " done"},        32'(done),        32'(v.dn));
        check({tag, " load_err"},    32'(load_err),    32'(v.err));
        check({tag, " cycle_count"}, cycle_count,      v.cnt);
        check({tag, " timeout"},     32'(timeout),     32'(v.tmo));
    endtask

    task automatic runTable(input vec_t tbl[$], input string name);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("%s[%0d]", name, i));
        end
    endtask

    // HOLD window: core stays in reset, no handshakes even if valid is high;
    // go and halt are offered to show they are ignored here.
    task automatic holdPhase(input int n, input int addr_i, input string name);
        vec_t v;
        for (int i = 1; i <= n; i++) begin
            v = mk(1, 1, 0, 0, 1, 0, 0, addr_i, 1, 0, 1, 0, 0, 0, 0);
            applyStimulus(v);
            checkOutput(v, $sformatf("%s[%0d]", name, i));
        end
    endtask

    // RUN cycles 1..n: cycle_count shows k-1 in RUN cycle k; halt is raised
    // in cycle halt_at (0 for never).
    task automatic runPhase(input int n, input int halt_at, input int addr_i, input string name);
        vec_t v;
        for (int k = 1; k <= n; k++) begin
            v = mk(0, 0, 0, 0, (k == halt_at) ? 1 : 0, 0, 0, addr_i, 0, 1, 1, 0, 0, k - 1, 0);
            applyStimulus(v);
            checkOutput(v, $sformatf("%s[%0d]", name, k));
        end
    endtask

    initial begin
        vec_t v;

        // Back-to-back load of 4 words, last on the 4th (from IDLE).
        t_load.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        t_load.push_back(mk(0, 1, 'h11,  0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        t_load.push_back(mk(0, 1, 'h22,  0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0));
        t_load.push_back(mk(0, 1, 'h33,  0, 0, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0));
        t_load.push_back(mk(0, 1, 'h44,  1, 0, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0));

        // Backpressure load started from DONE (previous run counted 25).
        t_bp.push_back(mk(1, 0, 0,      0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 25, 0));
        t_bp.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 1, 'hA1,   0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(1, 0, 0,      0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 1, 'hA2,   0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 0, 0,      0, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 1, 'hA3,   0, 0, 1, 1, 2, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 0, 0,      0, 0, 1, 0, 3, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 1, 'hA4,   1, 0, 1, 1, 3, 1, 0, 1, 0, 0, 0,  0));
        t_bp.push_back(mk(0, 1, 0,      0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0,  0));

        // Overflow: 5 words without last into a 4-word SRAM.
        t_ovf.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 1, 'hB0,  0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 1, 'hB1,  0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 1, 'hB2,  0, 0, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 1, 'hB3,  0, 0, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 1, 'hB4,  0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 0, 0));
        t_ovf.push_back(mk(0, 1, 'hB4,  0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 0, 0));

        // Reset held for 3 cycles with a go pulse: reset values throughout.
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = mk((i == 1) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            applyStimulus(v);
            checkOutput(v, $sformatf("in_reset[%0d]", i));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        go = 1'b0;
        #1;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "after_release");

        // Load, 10-cycle hold, release on L+11, halt in the 25th RUN cycle.
        runTable(t_load, "load");
        holdPhase(HOLD_CYCLES, 3, "hold1");
        runPhase(25, 25, 3, "run1");
        v = mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 25, 0);
        applyStimulus(v);
        checkOutput(v, "halted");
        v = mk(0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 1, 0, 25, 0);
        applyStimulus(v);
        checkOutput(v, "done_hold");

        // Rerun from DONE with backpressure, then reset asynchronously in RUN.
        runTable(t_bp, "bp");
        holdPhase(HOLD_CYCLES - 1, 3, "hold2");
        runPhase(5, 0, 3, "run2");
        #2 reset = 1'b0;
        #1;
        check("async core_start", 32'(core_start), 32'd0);
        check("async core_reset", 32'(core_reset), 32'd1);
        check("async busy", 32'(busy), 32'd0);
        check("async cycle_count", cycle_count, 32'd0);
        check("async mem_wr_addr", 32'(mem_wr_addr), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        runTable(t_ovf, "ovf");

        // Single-word image at address 0, then an unhalted run.
        v = mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(v);
        checkOutput(v, "wd_go");
        v = mk(0, 1, 'h55, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(v);
        checkOutput(v, "wd_load");
        holdPhase(HOLD_CYCLES, 1, "hold3");
`ifdef SP_RUN_WDOG_EN
        runPhase(50, 0, 1, "wd_run");
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 50, 1);
        applyStimulus(v);
        checkOutput(v, "wd_expired");

        // Halt in the same RUN cycle as watchdog expiry: halt wins.
        v = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 50, 1);
        applyStimulus(v);
        checkOutput(v, "tie_go");
        v = mk(0, 1, 'h66, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(v);
        checkOutput(v, "tie_load");
        holdPhase(HOLD_CYCLES, 1, "hold4");
        runPhase(50, 50, 1, "tie_run");
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 50, 0);
        applyStimulus(v);
        checkOutput(v, "tie_done");
`else
        runPhase(100, 0, 1, "nowd_run");
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 100, 0);
        applyStimulus(v);
        checkOutput(v, "nowd_still_run");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: got expired expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/sp_run_ctrl.md
# sp_run_ctrl

Synthesizable run controller for the SP core: streams a program/data image into the SP SRAM, holds the core in reset for a programmable number of cycles, then releases it with `start` asserted, and watches for halt. It also counts execution cycles and, when compiled in, enforces a watchdog limit. It replaces the fixed bench sequence (preload, fixed reset window, start) with a parametrised block usable on FPGA and in regression benches.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM word-address width; image capacity is 2^ADDR_W words
- `DATA_W`, 32, SRAM word width
- `HOLD_CYCLES`, 10, core-reset hold after load, ≥1
- `CNT_W`, 32, cycle counter width
- `MAX_CYCLES`, 1000000, watchdog limit, < 2^CNT_W

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-low
- `go` in 1 — start a load-and-run sequence
- `img_valid` in 1 — image word valid
- `img_data` in DATA_W — image word
- `img_last` in 1 — final image word
- `img_ready` out 1 — controller accepts image word
- `mem_wr_en` out 1 — SRAM write strobe
- `mem_wr_addr` out ADDR_W — SRAM write address
- `mem_wr_data` out DATA_W — SRAM write data
- `core_reset` out 1 — active-high reset to SP
- `core_start` out 1 — SP start level
- `core_halt` in 1 — SP halted
- `busy` out 1 — state ≠ IDLE/DONE
- `done` out 1 — sequence finished (sticky)
- `timeout` out 1 — watchdog expired (sticky)
- `load_err` out 1 — image overflowed SRAM (sticky)
- `cycle_count` out CNT_W — RUN cycles elapsed

## Operation
- States: IDLE, LOAD, HOLD, RUN, DONE.
- Reset values: state IDLE; `core_reset`=1, `core_start`=0, `img_ready`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `busy`=0, `done`=0, `timeout`=0, `load_err`=0, `cycle_count`=0.
- IDLE/DONE: `go`=1 → LOAD. This clears the address counter, `cycle_count`, `done`, `timeout`, and `load_err`. `go` is ignored in LOAD, HOLD, and RUN.
- LOAD: `img_ready`=1.
  - Handshake = `img_valid & img_ready`.
  - `mem_wr_en` = handshake (combinational); `mem_wr_addr` = address counter; `mem_wr_data` = `img_data`.
  - The counter increments per handshake.
  - Handshake with `img_last` → HOLD.
- Overflow: a handshake at address 2^ADDR_W−1 without `img_last` writes that word, then → DONE with `load_err`=1. The address counter does not wrap. `img_last` on the final address is legal and goes to HOLD.
- HOLD: `core_reset`=1. After exactly HOLD_CYCLES cycles → RUN.
- RUN:
  - `core_reset`=0, `core_start`=1.
  - `cycle_count` increments every RUN cycle and saturates at 2^CNT_W−1.
  - `core_halt`=1 → DONE, `done`=1.
- DONE: `core_reset`=1, `core_start`=0. `cycle_count` holds its final value.

## Timing
- `go` sampled in cycle N → `img_ready`=1 in N+1.
- Zero-latency write: the SRAM write occurs in the same cycle as the handshake.
- Last handshake in cycle L:
  - `img_ready`=0 from L+1.
  - `core_reset` deasserts at L+1+HOLD_CYCLES.
  - `core_start` rises on the same edge.
- `core_halt` sampled high in RUN cycle R → `done`=1, `core_start`=0, `core_reset`=1 in R+1. `cycle_count` includes cycle R.
- `core_halt` is ignored outside RUN.
- Simultaneous halt and watchdog expiry: halt wins, so `timeout`=0.
- `reset` low at any time forces reset values immediately, without waiting for a clock edge. Release is synchronous to the next edge and leaves the block in IDLE.

## Configuration
- `SP_RUN_WDOG_EN` defined:
  - In RUN, if `cycle_count` reaches MAX_CYCLES without `core_halt` → DONE with `timeout`=1 and `done`=1, on the cycle after the count hits MAX_CYCLES.
- Undefined:
  - No watchdog; `timeout` is tied to 0.
  - RUN persists until halt or reset.

## Test plan
- Reset checks: hold `reset`=0 for 3 cycles, then pulse `go` → all outputs at reset values during reset. After release, `img_ready`=1 the cycle after `go`.
- Load and run: stream 4 words 0x11,0x22,0x33,0x44 with `img_last` on the 4th, HOLD_CYCLES=10 → writes to addresses 0–3; `core_reset` falls exactly 11 cycles after the last handshake. Halt after 25 RUN cycles → `cycle_count`=25, `done`=1.
- Backpressure: toggle `img_valid` every other cycle → only 4 writes occur, with addresses contiguous.
- Overflow: ADDR_W=2, stream 5 words with no `img_last` → 4 writes, `load_err`=1, `done`=1, `core_start` never asserted.
- Watchdog: with `SP_RUN_WDOG_EN`, MAX_CYCLES=50, no halt → `timeout`=1 and `cycle_count`=50. Without the macro, run 100 cycles → still RUN, `timeout`=0.
- Mid-operation reset and rerun: assert `reset` during RUN → `core_start`=0 and `core_reset`=1 immediately. Then `go` from DONE → flags cleared and the address counter restarts at 0.
